// File: rtl/svm_pkg.sv
// Shared types and widths for the SVM kernel datapath.
// Datapath widths are tied to the default pixel geometry below.
package svm_pkg;

    localparam int DEF_XLEN_PIXEL    = 8;
    localparam int DEF_NUM_OF_PIXELS = 4;
    localparam int DEF_NUM_OF_SV     = 2;
    localparam int DEF_SV_ADDR_W     = 1;

    localparam int KW    = 4 * DEF_XLEN_PIXEL;
    localparam int ACC_W = 2 * DEF_XLEN_PIXEL + $clog2(DEF_NUM_OF_PIXELS);
    localparam int SQ_W  = 2 * ACC_W + 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        MAC   = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Clamp the squared kernel value into one KW-bit output slot.
    function automatic logic [KW-1:0] sat_kernel(input logic [SQ_W-1:0] sq);
        logic [KW-1:0] res;
        if (|sq[SQ_W-1:KW]) begin
            res = {KW{1'b1}};
        end else begin
            res = sq[KW-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/poly_kernel_engine_pixel_mac.sv
// Registered multiply-accumulate over one feature vector.
// A pixel counter steps through the vector one product per enabled cycle.
module pixel_mac
    import svm_pkg::*;
#(
    parameter int XLEN_PIXEL    = DEF_XLEN_PIXEL,
    parameter int NUM_OF_PIXELS = DEF_NUM_OF_PIXELS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic                                 en,
    input  logic [0:XLEN_PIXEL*NUM_OF_PIXELS-1]  x,
    input  logic [0:XLEN_PIXEL*NUM_OF_PIXELS-1]  sv,
    output logic [ACC_W-1:0]                     acc,
    output logic                                 last
);

    localparam int CNT_W = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1;

    logic [CNT_W-1:0]        cnt;
    logic [XLEN_PIXEL-1:0]   x_pix;
    logic [XLEN_PIXEL-1:0]   sv_pix;
    logic [2*XLEN_PIXEL-1:0] prod;

    assign last = (cnt == CNT_W'(NUM_OF_PIXELS - 1));

    // Select the current pixel pair and form its full-width product.
    always_comb begin
        x_pix  = x[int'(cnt)*XLEN_PIXEL +: XLEN_PIXEL];
        sv_pix = sv[int'(cnt)*XLEN_PIXEL +: XLEN_PIXEL];
        prod   = (2*XLEN_PIXEL)'(x_pix) * (2*XLEN_PIXEL)'(sv_pix);
    end

    // Accumulator and pixel counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
            cnt <= last ? CNT_W'(0) : cnt + CNT_W'(1);
        end else begin
            acc <= acc;
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/poly_kernel_engine.sv
// Degree-2 polynomial kernel (x.sv + 1)^2 against every support vector,
// packed into saturated slots for the downstream decision function.
module poly_kernel_engine
    import svm_pkg::*;
#(
    parameter int XLEN_PIXEL    = DEF_XLEN_PIXEL,
    parameter int NUM_OF_PIXELS = DEF_NUM_OF_PIXELS,
    parameter int NUM_OF_SV     = DEF_NUM_OF_SV,
    parameter int SV_ADDR_W     = DEF_SV_ADDR_W
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [0:XLEN_PIXEL*NUM_OF_PIXELS-1]       x_in,
    output logic [SV_ADDR_W-1:0]                      sv_addr,
    input  logic [0:XLEN_PIXEL*NUM_OF_PIXELS-1]       sv_data,
    output logic [0:4*XLEN_PIXEL*NUM_OF_SV-1]         kernel_out,
    output logic                                      decision_funct_en,
    output logic                                      busy
);

    state_t                              state;
    state_t                              next_state;
    logic [0:XLEN_PIXEL*NUM_OF_PIXELS-1] x_lat;
    logic [SV_ADDR_W-1:0]                idx;
    logic [ACC_W-1:0]                    acc;
    logic                                mac_last;
    logic [ACC_W:0]                      s_val;
    logic [SQ_W-1:0]                     sq;
    logic                                last_sv;
    logic                                accept;

    assign last_sv = (idx == SV_ADDR_W'(NUM_OF_SV - 1));
    assign accept  = start && ((state == IDLE) || (state == DONE));
    assign s_val   = {1'b0, acc} + (ACC_W+1)'(1);
    assign sq      = SQ_W'(s_val) * SQ_W'(s_val);

    pixel_mac #(
        .XLEN_PIXEL    (XLEN_PIXEL),
        .NUM_OF_PIXELS (NUM_OF_PIXELS)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (state == FETCH),
        .en    (state == MAC),
        .x     (x_lat),
        .sv    (sv_data),
        .acc   (acc),
        .last  (mac_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = FETCH; else next_state = IDLE;
            FETCH: next_state = MAC;
            MAC:   if (mac_last) next_state = POST; else next_state = MAC;
            POST:  if (last_sv) next_state = DONE; else next_state = FETCH;
            DONE:  if (start) next_state = FETCH; else next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_lat             <= '0;
            idx               <= '0;
            sv_addr           <= '0;
            kernel_out        <= '0;
            decision_funct_en <= 1'b0;
            busy              <= 1'b0;
        end else begin
            decision_funct_en <= (next_state == DONE);
            busy              <= (next_state == FETCH) || (next_state == MAC) ||
                                 (next_state == POST);
            if (accept) begin
                x_lat      <= x_in;
                idx        <= '0;
                sv_addr    <= '0;
                kernel_out <= '0;
            end else if (state == POST) begin
                kernel_out[int'(idx)*KW +: KW] <= sat_kernel(sq);
                if (!last_sv) begin
                    idx     <= idx + SV_ADDR_W'(1);
                    sv_addr <= idx + SV_ADDR_W'(1);
                end else begin
                    idx     <= idx;
                    sv_addr <= sv_addr;
                end
            end else begin
                x_lat   <= x_lat;
                idx     <= idx;
                sv_addr <= sv_addr;
            end
        end
    end

endmodule

// File: tb/tb_poly_kernel_engine.sv
// Randomized self-checking bench for poly_kernel_engine with an arithmetic
// reference model and a behavioural registered SV ROM.
module tb_poly_kernel_engine;

    localparam int P  = 4;
    localparam int NS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [0:31] x_in;
    logic [0:0]  sv_addr;
    logic [0:31] sv_data;
    logic [0:63] kernel_out;
    logic        decision_funct_en;
    logic        busy;

    logic [0:31] rom [0:NS-1];
    int          xpix [P];
    int          svpix [NS][P];
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    // Registered ROM: word appears one cycle after the address.
    always @(posedge clk) sv_data <= rom[sv_addr];

    poly_kernel_engine dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .x_in              (x_in),
        .sv_addr           (sv_addr),
        .sv_data           (sv_data),
        .kernel_out        (kernel_out),
        .decision_funct_en (decision_funct_en),
        .busy              (busy)
    );

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:31] pack(input int pix [P]);
        logic [0:31] v;
        for (int k = 0; k < P; k++) v[k*8 +: 8] = 8'(pix[k]);
        return v;
    endfunction

    // K_i = min((sum_k x[k]*sv_i[k] + 1)^2, 2^32-1); slot 0 is the leftmost word.
    function automatic logic [63:0] expected_kernels();
        logic [63:0] r;
        longint      dot;
        longint      sq;
        for (int i = 0; i < NS; i++) begin
            dot = 0;
            for (int k = 0; k < P; k++) dot += longint'(xpix[k]) * longint'(svpix[i][k]);
            sq = (dot + 1) * (dot + 1);
            if (sq > 64'hFFFF_FFFF) sq = 64'hFFFF_FFFF;
            r[63 - 32*i -: 32] = sq[31:0];
        end
        return r;
    endfunction

    task automatic load_rom();
        int tmp [P];
        for (int i = 0; i < NS; i++) begin
            for (int k = 0; k < P; k++) tmp[k] = svpix[i][k];
            rom[i] = pack(tmp);
        end
    endtask

    task automatic set_all(input int xv, input int s0, input int s1);
        for (int k = 0; k < P; k++) begin
            xpix[k]     = xv;
            svpix[0][k] = s0;
            svpix[1][k] = s1;
        end
    endtask

    // Full classification; optionally pulses a second start while busy.
    task automatic classify(input string tag, input bit pulse_busy);
        logic [63:0] exp;
        logic [0:0]  a0;
        logic [0:0]  a1;
        int          n;
        bit          seen;
        exp = expected_kernels();
        load_rom();
        x_in  = pack(xpix);
        start = 1'b1;
        step();
        start = 1'b0;
        check_value({tag, ".en_drop"}, 64'(decision_funct_en), 64'd0);
        check_value({tag, ".busy_on"}, 64'(busy), 64'd1);
        a0   = sv_addr;
        a1   = 1'b0;
        x_in = $urandom;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (pulse_busy && n == 4) begin
                start = 1'b1;
                x_in  = $urandom;
            end
            step();
            start = 1'b0;
            n++;
            if (n == 6) a1 = sv_addr;
            if (decision_funct_en) seen = 1'b1;
        end
        check_value({tag, ".latency"}, 64'(n), 64'd12);
        check_value({tag, ".kernel"}, kernel_out, exp);
        check_value({tag, ".busy_off"}, 64'(busy), 64'd0);
        check_value({tag, ".addr0"}, 64'(a0), 64'd0);
        check_value({tag, ".addr1"}, 64'(a1), 64'd1);
        step();
        check_value({tag, ".hold"}, kernel_out, exp);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        x_in  = '0;
        set_all(0, 0, 0);
        load_rom();
        step();
        step();
        check_value("reset.kernel", kernel_out, 64'd0);
        check_value("reset.en", 64'(decision_funct_en), 64'd0);
        check_value("reset.busy", 64'(busy), 64'd0);
        check_value("reset.addr", 64'(sv_addr), 64'd0);
        rst = 1'b0;
        step();

        for (int k = 0; k < P; k++) begin
            xpix[k]     = k + 1;
            svpix[0][k] = 1;
            svpix[1][k] = 0;
        end
        classify("basic", 1'b0);
        check_value("basic.slot0", 64'(kernel_out[0:31]), 64'd121);
        check_value("basic.slot1", 64'(kernel_out[32:63]), 64'd1);

        set_all(255, 255, 0);
        svpix[1][3] = 1;
        classify("sat", 1'b0);
        check_value("sat.slot0", 64'(kernel_out[0:31]), 64'hFFFF_FFFF);
        check_value("sat.slot1", 64'(kernel_out[32:63]), 64'd65536);

        for (int k = 0; k < P; k++) begin
            xpix[k]     = $urandom_range(255);
            svpix[0][k] = $urandom_range(255);
            svpix[1][k] = $urandom_range(255);
        end
        classify("busy_start", 1'b1);

        set_all(0, 7, 9);
        classify("b2b", 1'b0);
        check_value("b2b.slot0", 64'(kernel_out[0:31]), 64'd1);

        x_in  = 32'h0102_0304;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_value("midrst.kernel", kernel_out, 64'd0);
        check_value("midrst.en", 64'(decision_funct_en), 64'd0);
        check_value("midrst.busy", 64'(busy), 64'd0);
        check_value("midrst.addr", 64'(sv_addr), 64'd0);
        step();
        check_value("midrst.idle", 64'(busy), 64'd0);
        for (int k = 0; k < P; k++) begin
            xpix[k]     = $urandom_range(255);
            svpix[0][k] = $urandom_range(255);
            svpix[1][k] = $urandom_range(255);
        end
        classify("after_rst", 1'b0);

        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_value("rst_start.busy", 64'(busy), 64'd0);
            step();
        end
        check_value("rst_start.en", 64'(decision_funct_en), 64'd0);

        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < P; k++) begin
                xpix[k]     = $urandom_range(255);
                svpix[0][k] = $urandom_range(255);
                svpix[1][k] = (it == 0) ? 255 : $urandom_range(255);
            end
            classify("random", 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/poly_kernel_engine.md
Name: poly_kernel_engine

Overview:
Upstream stage of decision_funct in the cascaded SVM datapath. It computes the degree-2 polynomial kernel K(x,sv_i) = (x·sv_i + 1)^2 for one test vector against every support vector, which it reads one at a time from a registered SV ROM. It packs the saturated results into the kernel_out bus and raises decision_funct_en for the downstream block.

Parameters:
XLEN_PIXEL, 8, bits per unsigned pixel
NUM_OF_PIXELS, 4, pixels per feature vector
NUM_OF_SV, 2, number of support vectors
SV_ADDR_W, 1, SV ROM address width; must satisfy 2^SV_ADDR_W >= NUM_OF_SV

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a classification; honoured only in IDLE or DONE
x_in  in  [0:XLEN_PIXEL*NUM_OF_PIXELS-1]  test vector; pixel k = bits [k*XLEN_PIXEL +: XLEN_PIXEL]; sampled only on accepted start
sv_addr  out  SV_ADDR_W  SV ROM address
sv_data  in  [0:XLEN_PIXEL*NUM_OF_PIXELS-1]  ROM word, valid one cycle after sv_addr, same pixel packing as x_in
kernel_out  out  [0:4*XLEN_PIXEL*NUM_OF_SV-1]  slot i = bits [i*KW +: KW], KW = 4*XLEN_PIXEL
decision_funct_en  out  1  high while kernel_out is complete and valid
busy  out  1  high in FETCH/MAC/POST

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE; kernel_out=0; decision_funct_en=0; busy=0; sv_addr=0; accumulator, SV index and pixel counter all 0. Reset takes effect from any state, including mid-MAC; no partial result survives it.
- State IDLE: on start=1, latch x_in, set idx=0, clear kernel_out, go to FETCH.
- State FETCH (1 cycle): drive sv_addr=idx; clear accumulator; go to MAC.
- State MAC (NUM_OF_PIXELS cycles, k=0..P-1): acc += x[k]*sv_data[k]. Products are 2*XLEN_PIXEL bits unsigned. ACC width = 2*XLEN_PIXEL + clog2(NUM_OF_PIXELS), which cannot overflow. sv_addr is held constant, so sv_data is stable for the whole state. After k=P-1, go to POST.
- State POST (1 cycle): s = acc+1; sq = s*s at full width (2*ACC+2 bits). Write slot idx = min(sq, 2^KW-1) (saturate). If idx==NUM_OF_SV-1, go to DONE; otherwise idx++ and go to FETCH.
- State DONE: decision_funct_en=1, busy=0. kernel_out is held stable. decision_funct_en stays high until the next accepted start or rst. On start in DONE: drop decision_funct_en at the same edge, then proceed as from IDLE.
- start while busy is ignored and has no side effects.
- Latency: with start sampled at edge 0, decision_funct_en is first high after edge NUM_OF_SV*(NUM_OF_PIXELS+2). Defaults: 12 edges, i.e. visible in cycle 13.
- Intermediate slots are visible during operation, but they are valid only while decision_funct_en=1.
- rst and start at the same edge: rst wins.

Decomposition:
- Shared package svm_pkg:
  - state enum {IDLE, FETCH, MAC, POST, DONE}
  - localparams KW = 4*XLEN_PIXEL and ACC_W
  - function sat_kernel(sq) returning KW bits
- One sub-module, pixel_mac:
  - registered multiply-accumulate with clear/enable
  - pixel select by counter
  - the FSM stays in poly_kernel_engine.
- SV ROM is external; the bench models it.

Test Plan:
- Basic: x=[1,2,3,4], sv0=[1,1,1,1], sv1=[0,0,0,0] -> slot0=121 (0x00000079), slot1=1; decision_funct_en rises exactly 12 edges after start.
- Saturation: x and sv0 all 255 -> (260100+1)^2 exceeds 2^32-1, so slot0=0xFFFFFFFF. sv1=[0,0,0,1] with x[3]=255 -> slot1=256^2=65536.
- Start while busy: pulse start again at edge 5 with a different x_in -> ignored; results match the first x_in and latency is unchanged.
- Reset mid-operation: assert rst during MAC of SV1 -> next cycle kernel_out=0, en=0, busy=0, sv_addr=0; a fresh start then produces the correct result.
- Back-to-back: start in DONE with new x=[0,0,0,0] -> en drops at that edge; all slots =1 after a further 12 edges; ROM address sequence observed as 0 then 1.
- Simultaneous rst and start in IDLE -> remains IDLE; busy never asserts.
